// File: rtl/iitb_risc_mem_arbiter_pkg.sv
// Shared constants and types for the IITB RISC on-chip memory arbiter.
// Geometry matches the 64Kx16 single-port memory behind the arbiter.
package iitb_risc_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } rd_tag_t;

  // Loads always read the full word; only stores honour the CPU byte enables.
  function automatic logic [1:0] access_be(input logic we, input logic [1:0] be);
    return we ? be : 2'b11;
  endfunction

endpackage

// File: rtl/iitb_risc_mem_arbiter_if.sv
// CPU fetch/load-store ports plus the Avalon s1 memory port, bundled as one interface.
// slave = arbiter view; master = CPU and memory side that feeds it.
interface iitb_risc_mem_arbiter_if;
  import iitb_risc_mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_be;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_be, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/iitb_risc_mem_arbiter.sv
// Merges CPU fetch (I) and load/store (D) onto one memory port, one access per cycle;
// grant is combinational, read data returns with rvalid one cycle after the grant.
module iitb_risc_mem_arbiter
  import iitb_risc_mem_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  iitb_risc_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

  rd_tag_t           tag_q, tag_d;
  logic [3:0]        run_q, run_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;

  logic grant_i;
  logic grant_d;
  logic i_rv;
  logic d_rv;

  // D wins unless I has already waited through MAX_D_RUN consecutive D grants.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (bus.d_req && (!bus.i_req || (run_q < RUN_MAX))) begin
        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    run_d = run_q;
    if (!bus.i_req || grant_i) begin
      run_d = 4'd0;
    end else if (grant_d && (run_q != 4'hF)) begin
      run_d = run_q + 4'd1;
    end
  end

  always_comb begin
    addr_d = addr_q;
    be_d   = be_q;
    if (grant_d) begin
      addr_d = bus.d_addr;
      be_d   = access_be(bus.d_we, bus.d_be);
    end else if (grant_i) begin
      addr_d = bus.i_addr;
      be_d   = 2'b11;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (grant_i) begin
      tag_d = TAG_I;
    end else if (grant_d && !bus.d_we) begin
      tag_d = TAG_D;
    end
  end

  assign i_rv = (tag_q == TAG_I);
  assign d_rv = (tag_q == TAG_D);

  always_comb begin
    i_hold_d = i_hold_q;
    d_hold_d = d_hold_q;
    if (i_rv) begin
      i_hold_d = bus.mem_readdata;
    end
    if (d_rv) begin
      d_hold_d = bus.mem_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= TAG_NONE;
      run_q    <= 4'd0;
      addr_q   <= '0;
      be_q     <= 2'b00;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      tag_q    <= tag_d;
      run_q    <= run_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = i_rv;
  assign bus.d_rvalid = d_rv;
  assign bus.i_rdata  = i_hold_d;
  assign bus.d_rdata  = d_hold_d;

  // Idle cycles keep the last address so the memory pins do not toggle needlessly.
  assign bus.mem_address    = addr_d;
  assign bus.mem_byteenable = be_d;
  assign bus.mem_chipselect = grant_i | grant_d;
  assign bus.mem_write      = grant_d & bus.d_we;
  assign bus.mem_writedata  = bus.d_wdata;
  assign bus.mem_clken      = 1'b1;

endmodule

// File: tb/tb_iitb_risc_mem_arbiter.sv
// Directed scenarios followed by randomized I/D traffic, all checked against a
// transaction-level reference (golden memory, expected grants, pending read queue).
module tb_iitb_risc_mem_arbiter;
  localparam int MAX_D_RUN = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iitb_risc_mem_arbiter_if bus ();

  iitb_risc_mem_arbiter #(.MAX_D_RUN(MAX_D_RUN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory behind s1: registered read, byte-enabled write.
  logic [15:0] mem [0:65535];
  logic [15:0] gm  [0:65535];
  logic [15:0] rd_q = 16'h0;
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_write) begin
      if (bus.mem_byteenable[0]) mem[bus.mem_address][7:0]  <= bus.mem_writedata[7:0];
      if (bus.mem_byteenable[1]) mem[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
    end else if (bus.mem_chipselect) begin
      rd_q <= mem[bus.mem_address];
    end
  end
  assign bus.mem_readdata = rd_q;

  // Reference model: pending = 0 none, 1 fetch, 2 load.
  int          m_streak = 0;
  int          m_pend = 0;
  logic [15:0] m_val = 16'h0;
  logic [15:0] m_hold_i = 16'h0;
  logic [15:0] m_hold_d = 16'h0;
  logic [15:0] m_last_addr = 16'h0;

  always @(negedge clk) begin
    bit          exp_dg;
    bit          exp_ig;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    if (reset) begin
      check_eq("rst_i_gnt", 32'(bus.i_gnt), 0);
      check_eq("rst_d_gnt", 32'(bus.d_gnt), 0);
      check_eq("rst_i_rvalid", 32'(bus.i_rvalid), 0);
      check_eq("rst_d_rvalid", 32'(bus.d_rvalid), 0);
      check_eq("rst_cs", 32'(bus.mem_chipselect), 0);
      check_eq("rst_wr", 32'(bus.mem_write), 0);
      check_eq("rst_i_rdata", 32'(bus.i_rdata), 0);
      check_eq("rst_d_rdata", 32'(bus.d_rdata), 0);
      m_streak = 0;
      m_pend = 0;
      m_hold_i = 16'h0;
      m_hold_d = 16'h0;
      m_last_addr = 16'h0;
    end else begin
      exp_dg = bus.d_req && (!bus.i_req || m_streak < MAX_D_RUN);
      exp_ig = !exp_dg && bus.i_req;
      exp_addr = exp_dg ? bus.d_addr : (exp_ig ? bus.i_addr : m_last_addr);
      exp_be = (exp_dg && bus.d_we) ? bus.d_be : 2'b11;
      check_eq("i_gnt", 32'(bus.i_gnt), 32'(exp_ig));
      check_eq("d_gnt", 32'(bus.d_gnt), 32'(exp_dg));
      check_eq("chipselect", 32'(bus.mem_chipselect), 32'(exp_ig | exp_dg));
      check_eq("mem_write", 32'(bus.mem_write), 32'(exp_dg && bus.d_we));
      check_eq("mem_address", 32'(bus.mem_address), 32'(exp_addr));
      if (exp_ig || exp_dg) check_eq("mem_be", 32'(bus.mem_byteenable), 32'(exp_be));
      check_eq("mem_wdata", 32'(bus.mem_writedata), 32'(bus.d_wdata));
      check_eq("mem_clken", 32'(bus.mem_clken), 1);
      check_eq("i_rvalid", 32'(bus.i_rvalid), 32'(m_pend == 1));
      check_eq("d_rvalid", 32'(bus.d_rvalid), 32'(m_pend == 2));
      if (m_pend == 1) m_hold_i = m_val;
      if (m_pend == 2) m_hold_d = m_val;
      check_eq("i_rdata", 32'(bus.i_rdata), 32'(m_hold_i));
      check_eq("d_rdata", 32'(bus.d_rdata), 32'(m_hold_d));
      m_last_addr = exp_addr;
      m_pend = 0;
      if (exp_ig) begin
        m_pend = 1;
        m_val = gm[bus.i_addr];
      end else if (exp_dg && !bus.d_we) begin
        m_pend = 2;
        m_val = gm[bus.d_addr];
      end
      if (exp_dg && bus.d_we) begin
        if (bus.d_be[0]) gm[bus.d_addr][7:0]  = bus.d_wdata[7:0];
        if (bus.d_be[1]) gm[bus.d_addr][15:8] = bus.d_wdata[15:8];
      end
      if (!bus.i_req || exp_ig) m_streak = 0;
      else if (exp_dg) m_streak = m_streak + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    bit         ig_s;
    bit         dg_s;
    logic [15:0] v;
    bus.i_req = 1'b0; bus.i_addr = 16'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0;
    bus.d_be = 2'b11; bus.d_wdata = 16'h0;
    for (int a = 0; a < 65536; a++) begin
      v = 16'($urandom);
      mem[a] = v;
      gm[a] = v;
    end
    mem[16'h0010] = 16'hA5A5; gm[16'h0010] = 16'hA5A5;
    mem[16'h0100] = 16'hAAAA; gm[16'h0100] = 16'hAAAA;

    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Lone fetch.
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    @(negedge clk); check_eq("lone_gnt", 32'(bus.i_gnt), 1);
    tick(); bus.i_req = 1'b0;
    @(negedge clk);
    check_eq("lone_rvalid", 32'(bus.i_rvalid), 1);
    check_eq("lone_rdata", 32'(bus.i_rdata), 32'h0000A5A5);
    tick(); tick();
    @(negedge clk);
    check_eq("lone_held_rv", 32'(bus.i_rvalid), 0);
    check_eq("lone_held", 32'(bus.i_rdata), 32'h0000A5A5);

    // Store upper byte, then load the merged word.
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100;
    bus.d_be = 2'b10; bus.d_wdata = 16'h12FF;
    @(negedge clk); check_eq("st_gnt", 32'(bus.d_gnt), 1);
    tick();
    bus.d_we = 1'b0; bus.d_be = 2'b01; bus.d_wdata = 16'h0;
    @(negedge clk);
    check_eq("st_no_rvalid", 32'(bus.d_rvalid), 0);
    check_eq("ld_gnt", 32'(bus.d_gnt), 1);
    tick(); bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("ld_rvalid", 32'(bus.d_rvalid), 1);
    check_eq("ld_rdata", 32'(bus.d_rdata), 32'h000012AA);
    tick();

    // Both ports saturated: D gets MAX_D_RUN grants, then I gets one.
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.i_addr = 16'(16'h0200 + k);
      bus.d_addr = 16'(16'h0300 + k);
      @(negedge clk);
      pat[9-k] = bus.d_gnt;
      tick();
    end
    idle_inputs();
    check_eq("conflict_pat", 32'(pat), 32'b1111011110);
    tick();

    // Alternating single-port reads, one per cycle.
    for (int k = 0; k < 8; k++) begin
      bus.i_req = (k % 2 == 0);
      bus.d_req = (k % 2 == 1);
      bus.i_addr = 16'(16'h0400 + k);
      bus.d_addr = 16'(16'h0500 + k);
      tick();
    end
    idle_inputs();
    tick(); tick();

    // Reset between a fetch grant and its rvalid.
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    @(negedge clk); check_eq("rstrd_gnt", 32'(bus.i_gnt), 1);
    tick();
    reset = 1'b1; bus.i_req = 1'b0;
    @(negedge clk);
    check_eq("rstrd_no_rvalid", 32'(bus.i_rvalid), 0);
    check_eq("rstrd_rdata", 32'(bus.i_rdata), 0);
    tick(); reset = 1'b0;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    @(negedge clk); check_eq("refetch_gnt", 32'(bus.i_gnt), 1);
    tick(); bus.i_req = 1'b0;
    @(negedge clk);
    check_eq("refetch_rvalid", 32'(bus.i_rvalid), 1);
    check_eq("refetch_rdata", 32'(bus.i_rdata), 32'h0000A5A5);

    // Randomized traffic with held requests, early drops and sporadic resets.
    ig_s = 1'b0; dg_s = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (reset) begin
        idle_inputs();
      end else begin
        if (bus.i_req && !ig_s) begin
          if ($urandom_range(0, 19) == 0) bus.i_req = 1'b0;
        end else begin
          bus.i_req = ($urandom_range(0, 99) < 60);
          bus.i_addr = 16'($urandom_range(0, 31));
        end
        if (bus.d_req && !dg_s) begin
          if ($urandom_range(0, 19) == 0) bus.d_req = 1'b0;
        end else begin
          bus.d_req = ($urandom_range(0, 99) < 60);
          bus.d_we = $urandom_range(0, 1) == 1;
          bus.d_addr = 16'($urandom_range(0, 31));
          bus.d_be = 2'($urandom_range(0, 3));
          bus.d_wdata = 16'($urandom);
        end
      end
      @(negedge clk);
      ig_s = bus.i_gnt;
      dg_s = bus.d_gnt;
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
